// File: rtl/input_sync_debounce.sv
// Purpose: synchronises asynchronous board inputs, optionally debounces them, emits level plus rise/fall pulses, and builds the synced reset.
// Latency: SYNC_STAGES + D edges from a stable input to level/rise/fall; reset asserts at once and releases RST_STAGES edges after rstn_a rises.
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
module input_sync_debounce #(
    parameter int                N_CH            = 8,
    parameter int                SYNC_STAGES     = 2,
    parameter int                RST_STAGES      = 2,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter logic [N_CH-1:0]   DB_MASK         = '1,
    parameter int                CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rstn_a,
    input  logic [N_CH-1:0] in_a,
    output logic            reset,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    // Terminal count for debounced channels; bypassed channels act on the first differing sample.
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [RST_STAGES-1:0] rst_sr;
    logic [N_CH-1:0]       sync_q [SYNC_STAGES];
    logic [N_CH-1:0]       s;
    logic [N_CH-1:0]       s_next;
    logic [CNT_W-1:0]      cnt [N_CH];

    // Reset generator: cleared to all ones asynchronously, zeros shift in once rstn_a is released.
    always_ff @(posedge clk or negedge rstn_a) begin
        if (!rstn_a) begin
            rst_sr <= '1;
        end else begin
            rst_sr <= {rst_sr[RST_STAGES-2:0], 1'b0};
        end
    end

    assign reset = rst_sr[RST_STAGES-1];

    // Per-channel synchroniser chains; they keep running during the reset window.
    always_ff @(posedge clk or negedge rstn_a) begin
        if (!rstn_a) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in_a;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // s is the synchronised sample; s_next is what s becomes on this edge.
    assign s      = sync_q[SYNC_STAGES-1];
    assign s_next = sync_q[SYNC_STAGES-2];

    // Debounce filter and edge pulses. During the reset window level follows the chain
    // (loaded with the value s takes on the same edge, so level == s when the window closes
    // and the first normal cycle sees no false difference).
    always_ff @(posedge clk or negedge rstn_a) begin
        if (!rstn_a) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            if (reset) begin
                level <= s_next;
                for (int ch = 0; ch < N_CH; ch++) begin
                    cnt[ch] <= '0;
                end
            end else begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    if (s[ch] == level[ch]) begin
                        cnt[ch] <= '0;
                    end else if (!DB_MASK[ch] || (cnt[ch] == DB_LIMIT)) begin
                        level[ch] <= s[ch];
                        cnt[ch]   <= '0;
                        rise[ch]  <= s[ch];
                        fall[ch]  <= ~s[ch];
                    end else begin
                        cnt[ch] <= cnt[ch] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_input_sync_debounce.sv
// Purpose: randomized and directed stimulus for input_sync_debounce, checked every cycle against a sample-window model.
// Latency: outputs compared on each falling edge; directed checks sample 1 time unit after rising edges.
// Backpressure: none; stimulus changes 2 time units after a rising edge.
module tb_input_sync_debounce;

    localparam int             N    = 4;
    localparam int             SS   = 2;
    localparam int             RS   = 2;
    localparam int             DEB  = 8;
    localparam logic [N-1:0]   MASK = 4'b0011;

    logic         clk = 1'b0;
    logic         rstn_a;
    logic [N-1:0] in_a;
    logic         reset;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    input_sync_debounce #(
        .N_CH           (N),
        .SYNC_STAGES    (SS),
        .RST_STAGES     (RS),
        .DEBOUNCE_CYCLES(DEB),
        .DB_MASK        (MASK)
    ) dut (
        .clk   (clk),
        .rstn_a(rstn_a),
        .in_a  (in_a),
        .reset (reset),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Wait until just after the k-th rising edge from now.
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // pipe[0] is the sample the filter sees on the coming edge; in_a enters at the back.
    // hist[0] is the newest sample the filter has judged. A channel with limit D flips
    // when its last D judged samples all differ from its current level.
    logic [N-1:0] pipe [SS];
    logic [N-1:0] hist [DEB];
    logic [N-1:0] m_level, m_rise, m_fall;
    logic [N-1:0] m_seen, m_snext;
    logic         m_reset;
    int           rel_edges;
    int           m_d;
    bit           m_all;

    task automatic model_clear();
        for (int k = 0; k < SS; k++) pipe[k] = '0;
        for (int k = 0; k < DEB; k++) hist[k] = '0;
        m_level   = '0;
        m_rise    = '0;
        m_fall    = '0;
        m_reset   = 1'b1;
        rel_edges = 0;
    endtask

    always @(posedge clk or negedge rstn_a) begin
        if (!rstn_a) begin
            model_clear();
        end else begin
            m_seen = pipe[0];
            for (int k = 0; k < SS - 1; k++) pipe[k] = pipe[k+1];
            pipe[SS-1] = in_a;
            m_snext = pipe[0];
            m_rise  = '0;
            m_fall  = '0;
            if (rel_edges < RS) begin
                m_level = m_snext;
                for (int k = 0; k < DEB; k++) hist[k] = m_snext;
            end else begin
                for (int k = DEB - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = m_seen;
                for (int ch = 0; ch < N; ch++) begin
                    m_d   = MASK[ch] ? DEB : 1;
                    m_all = 1'b1;
                    for (int k = 0; k < m_d; k++) begin
                        if (hist[k][ch] == m_level[ch]) m_all = 1'b0;
                    end
                    if (m_all) begin
                        m_level[ch] = ~m_level[ch];
                        m_rise[ch]  = m_level[ch];
                        m_fall[ch]  = ~m_level[ch];
                    end
                end
            end
            if (rel_edges < RS) rel_edges++;
            m_reset = (rel_edges < RS);
        end
    end

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc reset", reset, m_reset);
            check("cyc level", level, m_level);
            check("cyc rise", rise, m_rise);
            check("cyc fall", fall, m_fall);
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] v;

    initial begin
        rstn_a = 1'b0;
        in_a   = 4'b1010;
        tick(3);
        cmp_en = 1'b1;
        check("rst reset", reset, 1);
        check("rst level", level, 0);
        check("rst rise", rise, 0);
        check("rst fall", fall, 0);

        // Reset release: two window edges, level captures the switches without pulses.
        #1 rstn_a = 1'b1;
        tick(1);
        check("rel e1 reset", reset, 1);
        tick(1);
        check("rel e2 reset", reset, 0);
        check("rel e2 level", level, 4'b1010);
        check("rel e2 rise", rise, 0);
        tick(12);

        // Bypass channel 2 rises: level after edge 3, pulse gone after edge 4.
        #1 in_a = 4'b1110;
        tick(2);
        check("byp e2 level2", level[2], 0);
        tick(1);
        check("byp e3 level2", level[2], 1);
        check("byp e3 rise", rise, 4'b0100);
        tick(1);
        check("byp e4 rise", rise, 0);
        tick(10);

        // Debounced channel 0 rises then falls: 10 edges each.
        #1 in_a = 4'b1111;
        tick(9);
        check("db e9 level0", level[0], 0);
        tick(1);
        check("db e10 level0", level[0], 1);
        check("db e10 rise", rise, 4'b0001);
        tick(1);
        check("db e11 rise", rise, 0);
        tick(5);
        #1 in_a = 4'b1110;
        tick(9);
        check("dbf e9 fall", fall, 0);
        tick(1);
        check("dbf e10 fall", fall, 4'b0001);
        check("dbf e10 level0", level[0], 0);
        tick(1);
        check("dbf e11 fall", fall, 0);
        tick(5);

        // Glitch rejection on channel 1.
        #1 in_a = 4'b1100;
        tick(12);
        check("gl settle level", level, 4'b1100);
        #1 in_a = 4'b1110;
        tick(5);
        #1 in_a = 4'b1100;
        tick(1);
        #1 in_a = 4'b1110;
        tick(5);
        check("gl e5 level1", level[1], 0);
        tick(4);
        check("gl e9 level1", level[1], 0);
        tick(1);
        check("gl e10 level1", level[1], 1);
        check("gl e10 rise", rise, 4'b0010);
        tick(12);

        // All four channels flip together.
        #1 in_a = 4'b0001;
        tick(2);
        check("sim e2 fall", fall, 0);
        tick(1);
        check("sim e3 fall", fall, 4'b1100);
        check("sim e3 rise", rise, 0);
        check("sim e3 level", level, 4'b0010);
        tick(1);
        check("sim e4 fall", fall, 0);
        tick(5);
        check("sim e9 rise", rise, 0);
        tick(1);
        check("sim e10 rise", rise, 4'b0001);
        check("sim e10 fall", fall, 4'b0010);
        check("sim e10 level", level, 4'b0001);
        tick(1);
        check("sim e11 rise", rise, 0);
        check("sim e11 fall", fall, 0);

        // Random inputs with varied hold times and occasional resets.
        for (int t = 0; t < 150; t++) begin
            #1 in_a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) begin
                rstn_a = 1'b0;
                tick(int'($urandom_range(1, 3)));
                #1 rstn_a = 1'b1;
            end
            tick(int'($urandom_range(1, 12)));
        end

        // Reset mid-count: everything clears at once, then level reloads with no pulse.
        tick(14);
        check("mid settle level", level, in_a);
        v = in_a ^ 4'b0001;
        #1 in_a = v;
        tick(4);
        #1 rstn_a = 1'b0;
        #1;
        check("mid reset", reset, 1);
        check("mid level", level, 0);
        check("mid rise", rise, 0);
        check("mid fall", fall, 0);
        tick(2);
        #1 rstn_a = 1'b1;
        tick(2);
        check("mid rel reset", reset, 0);
        check("mid rel level", level, v);
        check("mid rel rise", rise, 0);
        tick(3);
        check("mid rel e5 rise", rise, 0);
        check("mid rel e5 fall", fall, 0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
